// File: rtl/call_stack_n.sv
// -----------------------------------------------------------------------------
// call_stack_n
// Parametrised hardware return-address stack. The controller pushes on CALL
// and pops on RETLW; top_data feeds the stack input of the PC multiplexer.
//
// Parameters:
//   AW    - width of each stored return address
//   DEPTH - number of entries (2..16)
//   WRAP  - 1: push when full overwrites the oldest entry
//           0: push when full is dropped
//   LW    - width of the level output (derived, do not override)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   push      in   store push_data as the new top-of-stack
//   pop       in   discard top-of-stack
//   push_data in   return address to store
//   clr_err   in   synchronous clear of ovf/unf (and hwm when enabled)
//   top_data  out  current top-of-stack, 0 when empty
//   level     out  number of valid entries
//   empty     out  level == 0
//   full      out  level == DEPTH
//   ovf       out  sticky: push while full
//   unf       out  sticky: pop while empty
//   hwm       out  high-water mark of level (only with CALL_STACK_HWM_EN)
//
// Optional feature macro: CALL_STACK_HWM_EN
// -----------------------------------------------------------------------------
module call_stack_n #(
    parameter int AW    = 9,
    parameter int DEPTH = 2,
    parameter int WRAP  = 1,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    input  logic          clr_err,
    output logic [AW-1:0] top_data,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
`ifdef CALL_STACK_HWM_EN
    ,
    output logic [LW-1:0] hwm
`endif
);

    localparam int             SPW     = $clog2(DEPTH);
    localparam logic [SPW-1:0] SP_MAX  = SPW'(DEPTH - 1);
    localparam logic [LW-1:0]  LV_FULL = LW'(DEPTH);

    logic [SPW-1:0] sp_reg, sp_next;
    logic [LW-1:0]  level_reg, level_next;
    logic           ovf_reg, ovf_next;
    logic           unf_reg, unf_next;

    logic [SPW-1:0] sp_inc, sp_dec;
    logic           empty_w, full_w;
    logic           wr_en;
    logic [SPW-1:0] wr_addr;
    logic           ovf_evt, unf_evt;

    logic [AW-1:0]  rd_arr [DEPTH];

    // Explicit compares so that non-power-of-2 depths wrap correctly.
    assign sp_inc  = (sp_reg == SP_MAX) ? '0 : sp_reg + 1'b1;
    assign sp_dec  = (sp_reg == '0) ? SP_MAX : sp_reg - 1'b1;

    assign empty_w = (level_reg == '0);
    assign full_w  = (level_reg == LV_FULL);

    always_comb begin
        sp_next    = sp_reg;
        level_next = level_reg;
        wr_en      = 1'b0;
        wr_addr    = sp_reg;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!full_w) begin
                    wr_en      = 1'b1;
                    sp_next    = sp_inc;
                    level_next = level_reg + 1'b1;
                end else begin
                    ovf_evt = 1'b1;
                    if (WRAP != 0) begin
                        // Writing at sp overwrites the oldest entry.
                        wr_en   = 1'b1;
                        sp_next = sp_inc;
                    end
                end
            end
            2'b01: begin
                if (!empty_w) begin
                    sp_next    = sp_dec;
                    level_next = level_reg - 1'b1;
                end else begin
                    unf_evt = 1'b1;
                end
            end
            2'b11: begin
                if (!empty_w) begin
                    // Replace the top entry in place.
                    wr_en   = 1'b1;
                    wr_addr = sp_dec;
                end else begin
                    // Nothing to pop: behaves as a plain push, but flags it.
                    wr_en      = 1'b1;
                    sp_next    = sp_inc;
                    level_next = LW'(1);
                    unf_evt    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A new error event in the same cycle as clr_err wins.
    assign ovf_next = (ovf_reg & ~clr_err) | ovf_evt;
    assign unf_next = (unf_reg & ~clr_err) | unf_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_reg    <= '0;
            level_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            sp_reg    <= sp_next;
            level_reg <= level_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Entry storage. Each entry is its own register so top_data can be read
    // combinationally; popped entries keep their contents.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [AW-1:0] ent_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ent_reg <= '0;
                end else if (wr_en && (wr_addr == SPW'(gi))) begin
                    ent_reg <= push_data;
                end
            end
            assign rd_arr[gi] = ent_reg;
        end
    endgenerate

`ifdef CALL_STACK_HWM_EN
    logic [LW-1:0] hwm_reg, hwm_next;

    assign hwm_next = clr_err ? level_next :
                      ((level_next > hwm_reg) ? level_next : hwm_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_reg <= '0;
        end else begin
            hwm_reg <= hwm_next;
        end
    end

    assign hwm = hwm_reg;
`endif

    assign top_data = empty_w ? '0 : rd_arr[sp_dec];
    assign level    = level_reg;
    assign empty    = empty_w;
    assign full     = full_w;
    assign ovf      = ovf_reg;
    assign unf      = unf_reg;

endmodule

// File: tb/tb_call_stack_n.sv
// -----------------------------------------------------------------------------
// tb_call_stack_n
// Directed bench for call_stack_n. Three instances share clock and reset:
//   u0: DEPTH=2, WRAP=1    u1: DEPTH=2, WRAP=0    u2: DEPTH=5, WRAP=1
// hwm checks are compiled in only when CALL_STACK_HWM_EN is defined.
// -----------------------------------------------------------------------------
module tb_call_stack_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push [3];
    logic       pop  [3];
    logic       clr  [3];
    logic [8:0] pd   [3];

    logic [8:0] top0, top1, top2;
    logic [1:0] lvl0, lvl1;
    logic [2:0] lvl2;
    logic       emp0, emp1, emp2;
    logic       ful0, ful1, ful2;
    logic       ovf0, ovf1, ovf2;
    logic       unf0, unf1, unf2;
`ifdef CALL_STACK_HWM_EN
    logic [1:0] hwm0, hwm1;
    logic [2:0] hwm2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    call_stack_n #(.AW(9), .DEPTH(2), .WRAP(1)) u0 (
        .clk(clk), .rst(rst), .push(push[0]), .pop(pop[0]), .push_data(pd[0]),
        .clr_err(clr[0]), .top_data(top0), .level(lvl0), .empty(emp0),
        .full(ful0), .ovf(ovf0), .unf(unf0)
`ifdef CALL_STACK_HWM_EN
        , .hwm(hwm0)
`endif
    );

    call_stack_n #(.AW(9), .DEPTH(2), .WRAP(0)) u1 (
        .clk(clk), .rst(rst), .push(push[1]), .pop(pop[1]), .push_data(pd[1]),
        .clr_err(clr[1]), .top_data(top1), .level(lvl1), .empty(emp1),
        .full(ful1), .ovf(ovf1), .unf(unf1)
`ifdef CALL_STACK_HWM_EN
        , .hwm(hwm1)
`endif
    );

    call_stack_n #(.AW(9), .DEPTH(5), .WRAP(1)) u2 (
        .clk(clk), .rst(rst), .push(push[2]), .pop(pop[2]), .push_data(pd[2]),
        .clr_err(clr[2]), .top_data(top2), .level(lvl2), .empty(emp2),
        .full(ful2), .ovf(ovf2), .unf(unf2)
`ifdef CALL_STACK_HWM_EN
        , .hwm(hwm2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus on instance i; outputs are sampled by the
    // caller #1 after the edge.
    task automatic cyc(input int i, input logic ps, input logic pp,
                       input logic cl, input logic [8:0] d);
        push[i] = ps;
        pop[i]  = pp;
        clr[i]  = cl;
        pd[i]   = d;
        @(posedge clk);
        #1;
        push[i] = 1'b0;
        pop[i]  = 1'b0;
        clr[i]  = 1'b0;
        pd[i]   = '0;
        $display("txn inst=%0d push=%0b pop=%0b clr=%0b data=%03h", i, ps, pp, cl, d);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            push[i] = 1'b0;
            pop[i]  = 1'b0;
            clr[i]  = 1'b0;
            pd[i]   = '0;
        end

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_level", 32'(lvl0), 32'd0);
        chk("rst_empty", 32'(emp0), 32'd1);
        chk("rst_full",  32'(ful0), 32'd0);
        chk("rst_top",   32'(top0), 32'h000);
        chk("rst_flags", {30'd0, ovf0, unf0}, 32'd0);
        rst = 1'b0;

        // Basic push/pop on u0
        cyc(0, 1, 0, 0, 9'h010);
        chk("p1_level", 32'(lvl0), 32'd1);
        chk("p1_top",   32'(top0), 32'h010);
        cyc(0, 1, 0, 0, 9'h020);
        chk("p2_level", 32'(lvl0), 32'd2);
        chk("p2_top",   32'(top0), 32'h020);
        chk("p2_full",  32'(ful0), 32'd1);
        cyc(0, 0, 1, 0, 9'h000);
        chk("pop1_top", 32'(top0), 32'h010);
        cyc(0, 0, 1, 0, 9'h000);
        chk("pop2_top",   32'(top0), 32'h000);
        chk("pop2_empty", 32'(emp0), 32'd1);
        chk("pop2_unf",   32'(unf0), 32'd0);

        // Overflow with WRAP=1 (u0) and WRAP=0 (u1)
        cyc(0, 1, 0, 0, 9'h001);
        cyc(0, 1, 0, 0, 9'h002);
        chk("w1_noovf", 32'(ovf0), 32'd0);
        cyc(0, 1, 0, 0, 9'h003);
        chk("w1_level", 32'(lvl0), 32'd2);
        chk("w1_ovf",   32'(ovf0), 32'd1);
        chk("w1_top",   32'(top0), 32'h003);
        cyc(0, 0, 1, 0, 9'h000);
        chk("w1_pop_top", 32'(top0), 32'h002);

        cyc(1, 1, 0, 0, 9'h001);
        cyc(1, 1, 0, 0, 9'h002);
        cyc(1, 1, 0, 0, 9'h003);
        chk("w0_level", 32'(lvl1), 32'd2);
        chk("w0_ovf",   32'(ovf1), 32'd1);
        chk("w0_top",   32'(top1), 32'h002);
        cyc(1, 0, 1, 0, 9'h000);
        chk("w0_pop_top", 32'(top1), 32'h001);

        // Underflow and clr_err on u0 (currently level 1)
        cyc(0, 0, 1, 0, 9'h000);
        chk("u_empty", 32'(emp0), 32'd1);
        cyc(0, 0, 1, 0, 9'h000);
        chk("u_unf",   32'(unf0), 32'd1);
        chk("u_level", 32'(lvl0), 32'd0);
        chk("u_top",   32'(top0), 32'h000);
        cyc(0, 0, 0, 1, 9'h000);
        chk("clr_unf", 32'(unf0), 32'd0);
        chk("clr_ovf", 32'(ovf0), 32'd0);
        cyc(0, 0, 1, 1, 9'h000);
        chk("clr_evt_wins", 32'(unf0), 32'd1);
        cyc(0, 0, 0, 1, 9'h000);

        // Simultaneous push & pop
        cyc(0, 1, 0, 0, 9'h055);
        chk("pp_pre_top", 32'(top0), 32'h055);
        cyc(0, 1, 1, 0, 9'h0AA);
        chk("pp_level", 32'(lvl0), 32'd1);
        chk("pp_top",   32'(top0), 32'h0AA);
        chk("pp_flags", {30'd0, ovf0, unf0}, 32'd0);
        cyc(0, 0, 1, 0, 9'h000);
        cyc(0, 1, 1, 0, 9'h0AA);
        chk("ppe_level", 32'(lvl0), 32'd1);
        chk("ppe_top",   32'(top0), 32'h0AA);
        chk("ppe_unf",   32'(unf0), 32'd1);

        // DEPTH=5 wrap: entries end as [6,7,3,4,5], sp=2
        for (int k = 1; k <= 7; k++) begin
            cyc(2, 1, 0, 0, 9'(k));
        end
        chk("d5_level7", 32'(lvl2), 32'd5);
        chk("d5_top7",   32'(top2), 32'h007);
        chk("d5_ovf",    32'(ovf2), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(2, 0, 1, 0, 9'h000);
        end
        chk("d5_level", 32'(lvl2), 32'd2);
        chk("d5_top",   32'(top2), 32'h004);
`ifdef CALL_STACK_HWM_EN
        chk("d5_hwm", 32'(hwm2), 32'd5);
`endif
        cyc(2, 0, 0, 1, 9'h000);
        chk("d5_clr_ovf", 32'(ovf2), 32'd0);
`ifdef CALL_STACK_HWM_EN
        chk("d5_clr_hwm", 32'(hwm2), 32'd2);
`endif

        // Asynchronous reset mid-run with u0 full
        cyc(0, 1, 0, 0, 9'h0BB);
        chk("ar_pre_level", 32'(lvl0), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_level", 32'(lvl0), 32'd0);
        chk("ar_empty", 32'(emp0), 32'd1);
        chk("ar_top",   32'(top0), 32'h000);
        chk("ar_flags", {30'd0, ovf0, unf0}, 32'd0);
        chk("ar_level2", 32'(lvl2), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 1, 0, 0, 9'h123);
        chk("post_rst_top",   32'(top0), 32'h123);
        chk("post_rst_level", 32'(lvl0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/call_stack_n.md
Name: call_stack_n

Overview:
- Parametrised hardware return-address stack; next generation of the 2-level PC stack in the pic10f200 core.
- Generalised in depth and address width, with selectable overflow mode, occupancy count and sticky error flags.
- Sits between pc and pc_mux. The controller issues push on CALL and pop on RETLW. top_data feeds the pc_mux stack input.

Parameters:
- AW, 9, width of each stored return address (PC width).
- DEPTH, 2, number of entries; legal range 2..16.
- WRAP, 1, 1 = circular overwrite of oldest entry when full (PIC-compatible); 0 = saturate, i.e. drop the push when full.
- LW, $clog2(DEPTH+1), width of level output (derived; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- push  in  1  store push_data as the new top-of-stack.
- pop  in  1  discard top-of-stack.
- push_data  in  AW  return address (pc_out + 1, formed by the caller).
- clr_err  in  1  synchronous clear of ovf/unf (and hwm when enabled).
- top_data  out  AW  current top-of-stack; 0 when empty.
- level  out  LW  number of valid entries, 0..DEPTH.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- ovf  out  1  sticky: a push occurred while full.
- unf  out  1  sticky: a pop occurred while empty.

Behaviour:
- Reset state (async, rst=1): all entries 0, write pointer 0, level 0, top_data 0, empty 1, full 0, ovf 0, unf 0.
- Storage: DEPTH x AW register array with circular write pointer sp. Top-of-stack is entry (sp-1) mod DEPTH.
- top_data is combinational from registers. A push is visible on top_data in the cycle after the edge. A pop exposes the previous entry in the cycle after the edge.
- Push only, not full: entry[sp] <= push_data; sp <= sp+1 mod DEPTH; level +1.
- Push only, full, WRAP=1: write as above, overwriting the oldest entry; level stays DEPTH; ovf <= 1.
- Push only, full, WRAP=0: no write, sp/level unchanged; ovf <= 1.
- Pop only, not empty: sp <= sp-1 mod DEPTH; level -1. Entry contents are not cleared.
- Pop only, empty: no state change; unf <= 1; top_data stays 0.
- push & pop same cycle, not empty: top entry replaced by push_data; sp/level unchanged; no flag set.
- push & pop same cycle, empty: treated as push-only (level becomes 1); unf <= 1.
- clr_err: ovf/unf <= 0 this edge. A new error event in the same cycle wins, so the flag ends up 1.
- Wrap rule: sp wraps modulo DEPTH for non-power-of-2 DEPTH (explicit compare, not bit truncation).
- Reset asserted mid-operation: immediate return to the reset state. Any push/pop sampled on the deassertion edge is processed normally.

Optional Feature:
- Macro: CALL_STACK_HWM_EN.
- Defined: adds output hwm [LW] = high-water mark of level since reset or the last clr_err.
  - Updated at the same edge as level, to max(hwm, next level).
  - clr_err loads hwm with the current next level.
- Not defined: no hwm port and no extra logic. All other behaviour is identical.

Test Plan:
- Reset check (DEPTH=2, AW=9): assert rst mid-run with level=2 -> level=0, empty=1, top_data=0, ovf=unf=0 without waiting for a clock edge.
- Push 0x010, then 0x020 -> level 1 then 2, top_data 0x010 then 0x020, full=1. Pop twice -> top_data 0x010 then 0, empty=1, unf=0.
- WRAP=1, DEPTH=2: push 0x001, 0x002, 0x003 -> level=2, ovf=1, top_data=0x003. Pop -> top_data 0x002.
  - Same sequence with WRAP=0 -> top_data stays 0x002, ovf=1. Pop -> 0x001.
- Pop on empty -> unf=1, level=0. clr_err for one cycle -> unf=0. Pop on empty with clr_err in the same cycle -> unf=1.
- Simultaneous push&pop with level=1, top=0x055, push_data=0x0AA -> level=1, top=0x0AA.
  - Same stimulus when empty -> level=1, top=0x0AA, unf=1.
- DEPTH=5, CALL_STACK_HWM_EN defined: 7 pushes (WRAP=1), then 3 pops -> level=2, hwm=5, ovf=1, sp wrapped correctly (top = 4th pushed value). clr_err -> hwm=2.
